// File: rtl/mult_seq_arbiter.sv
// ---------------------------------------------------------------------------
// mult_seq_arbiter
//   Sequential shift-and-add multiplier shared by two requesters through a
//   round-robin front end. A single WIDTH-bit adder performs one add per
//   cycle, so a multiply takes WIDTH cycles. The 2*WIDTH-bit product comes
//   back tagged with the ID of the requester that issued it.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous active-high reset
//   req0/a0/b0     : requester 0 request and unsigned operands (a * b)
//   req1/a1/b1     : requester 1 request and unsigned operands
//   gnt0/gnt1      : one-cycle pulse, operands captured for that requester
//   busy           : high while a multiply is in CALC or DONE
//   done0/done1    : one-cycle pulse, product valid for that requester
//   product        : last completed product, held until the next completion
//   prod_id        : requester ID that goes with product
// ---------------------------------------------------------------------------
module mult_seq_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic [WIDTH-1:0]     a0,
   input  logic [WIDTH-1:0]     b0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     a1,
   input  logic [WIDTH-1:0]     b1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 busy,
   output logic                 done0,
   output logic                 done1,
   output logic [2*WIDTH-1:0]   product,
   output logic                 prod_id
);

   localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_rr;
   logic                 r_cur_id;
   logic [SW-1:0]        r_step;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_gnt0;
   logic                 r_gnt1;
   logic                 r_done0;
   logic                 r_done1;
   logic                 r_busy;
   logic [2*WIDTH-1:0]   r_product;
   logic                 r_prod_id;

   logic                 w_any;
   logic                 w_win;
   logic [WIDTH-1:0]     w_a;
   logic [WIDTH-1:0]     w_b;
   logic [WIDTH-1:0]     w_addend;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_acc_nxt;

   // Winner is requester 1 when it is alone, or when both request and the
   // priority pointer currently favours it.
   always_comb begin
      w_any     = req0 | req1;
      w_win     = req1 & (~req0 | r_rr);
      w_a       = w_win ? a1 : a0;
      w_b       = w_win ? b1 : b0;
      w_addend  = r_mplier[0] ? r_mcand : '0;
      w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
      // Shift right by one with the adder carry entering the MSB.
      w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rr      <= 1'b0;
         r_cur_id  <= 1'b0;
         r_step    <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_busy    <= 1'b0;
         r_product <= '0;
         r_prod_id <= 1'b0;
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state  <= S_CALC;
                  r_mcand  <= w_a;
                  r_mplier <= w_b;
                  r_acc    <= '0;
                  r_step   <= '0;
                  r_cur_id <= w_win;
                  r_rr     <= ~w_win;
                  r_gnt0   <= ~w_win;
                  r_gnt1   <= w_win;
                  r_busy   <= 1'b1;
               end
            end
            S_CALC: begin
               r_acc    <= w_acc_nxt;
               r_mplier <= r_mplier >> 1;
               r_step   <= r_step + 1'b1;
               if (r_step == LAST_STEP) begin
                  // Product is taken from the final iteration's result.
                  r_state   <= S_DONE;
                  r_product <= w_acc_nxt;
                  r_prod_id <= r_cur_id;
                  r_done0   <= ~r_cur_id;
                  r_done1   <= r_cur_id;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign busy    = r_busy;
   assign done0   = r_done0;
   assign done1   = r_done1;
   assign product = r_product;
   assign prod_id = r_prod_id;

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_arbiter
//   Self-checking bench for mult_seq_arbiter (WIDTH=4). A transaction-level
//   reference model (product = a*b, round-robin winner, fixed latency
//   counter) predicts every output each cycle; directed scenarios add
//   explicit checks on products, grant order and latency.
// ---------------------------------------------------------------------------
module tb_mult_seq_arbiter;

   localparam int unsigned W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0, req1;
   logic [W-1:0]   a0, b0, a1, b1;
   logic           gnt0, gnt1, busy, done0, done1, prod_id;
   logic [2*W-1:0] product;

   mult_seq_arbiter #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (req0),
      .a0      (a0),
      .b0      (b0),
      .req1    (req1),
      .a1      (a1),
      .b1      (b1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .busy    (busy),
      .done0   (done0),
      .done1   (done1),
      .product (product),
      .prod_id (prod_id)
   );

   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;
   int unsigned cyc   = 0;

   // Reference model state
   int unsigned m_left = 0;   // cycles until the engine is free again
   bit          m_rr   = 1'b0;
   bit          m_id   = 1'b0;
   int unsigned m_pa   = 0;   // product of the operation in flight
   int unsigned m_prod = 0;
   bit          m_pid  = 1'b0;
   bit          e_gnt0, e_gnt1, e_done0, e_done1, e_busy;

   // Observed DUT grants
   int          g_port[$];
   int unsigned g_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit w;
      e_gnt0  = 1'b0;
      e_gnt1  = 1'b0;
      e_done0 = 1'b0;
      e_done1 = 1'b0;
      if (rst) begin
         m_left = 0;
         m_rr   = 1'b0;
         m_prod = 0;
         m_pid  = 1'b0;
      end else if (m_left == 0) begin
         if (req0 || req1) begin
            w      = (req0 && req1) ? m_rr : req1;
            m_rr   = !w;
            m_id   = w;
            m_pa   = w ? a1 * b1 : a0 * b0;
            m_left = W + 1;
            e_gnt0 = !w;
            e_gnt1 = w;
         end
      end else begin
         m_left--;
         if (m_left == 1) begin
            m_prod  = m_pa;
            m_pid   = m_id;
            e_done0 = !m_id;
            e_done1 = m_id;
         end
      end
      e_busy = (m_left != 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      if (gnt0 === 1'b1) begin g_port.push_back(0); g_cyc.push_back(cyc); end
      if (gnt1 === 1'b1) begin g_port.push_back(1); g_cyc.push_back(cyc); end
      check("gnt0",    gnt0,    e_gnt0);
      check("gnt1",    gnt1,    e_gnt1);
      check("busy",    busy,    e_busy);
      check("done0",   done0,   e_done0);
      check("done1",   done1,   e_done1);
      check("product", product, m_prod);
      check("prod_id", prod_id, m_pid);
   endtask

   // One isolated multiply on port p, started from IDLE; returns to IDLE.
   task automatic do_op(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int unsigned exp_prod);
      int unsigned t;
      bit seen;
      if (p) begin req1 = 1'b1; a1 = a; b1 = b; end
      else   begin req0 = 1'b1; a0 = a; b0 = b; end
      t = 0; seen = 1'b0;
      while (!seen && t < 20) begin
         tick(); t++;
         if ((p ? gnt1 : gnt0) === 1'b1) seen = 1'b1;
      end
      check("gnt_seen", seen, 1);
      if (p) req1 = 1'b0; else req0 = 1'b0;
      t = 0; seen = 1'b0;
      while (!seen && t < 20) begin
         tick(); t++;
         if ((p ? done1 : done0) === 1'b1) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      check("latency",   t, W);
      check("op_prod",   product, exp_prod);
      check("op_id",     prod_id, p);
      tick();
   endtask

   initial begin
      int unsigned base, t_g1, t_d1, n_done;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_prod", product, 0);
      check("rst_busy", busy, 0);

      // Single requests
      do_op(1'b0, 4'd15, 4'd15, 225);
      do_op(1'b1, 4'd0,  4'd9,  0);
      tick(); tick();
      check("hold_prod", product, 0);
      do_op(1'b1, 4'd13, 4'd11, 143);

      // Simultaneous requests after reset
      rst = 1'b1; tick(); rst = 1'b0;
      g_port.delete(); g_cyc.delete();
      base = cyc; t_g1 = 0; t_d1 = 0;
      req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
      req1 = 1'b1; a1 = 4'd7; b1 = 4'd6;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (gnt0 === 1'b1) req0 = 1'b0;
         if (gnt1 === 1'b1) begin req1 = 1'b0; t_g1 = cyc - base; end
         if (done0 === 1'b1) check("tie_prod0", product, 15);
         if (done1 === 1'b1) t_d1 = cyc - base;
      end
      check("tie_first", (g_port.size() > 0) ? g_port[0] : 9, 0);
      check("tie_gnt1_cyc",  t_g1, 7);
      check("tie_done1_cyc", t_d1, 11);
      check("tie_prod1", product, 42);

      // Continuous requests on both ports
      rst = 1'b1; tick(); rst = 1'b0;
      g_port.delete(); g_cyc.delete();
      req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
      req1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom);
      for (int i = 0; i < 36; i++) begin
         tick();
         if (gnt0 === 1'b1) begin a0 = W'($urandom); b0 = W'($urandom); end
         if (gnt1 === 1'b1) begin a1 = W'($urandom); b1 = W'($urandom); end
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("rr_count", g_port.size(), 6);
      for (int i = 0; i < g_port.size() && i < 6; i++) begin
         check("rr_order", g_port[i], i % 2);
         if (i > 0) check("rr_interval", g_cyc[i] - g_cyc[i-1], W + 2);
      end

      // Reset in the middle of a multiply
      req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
      tick();
      req0 = 1'b0;
      tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("abort_prod", product, 0);
      check("abort_busy", busy, 0);
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done0 === 1'b1 || done1 === 1'b1) n_done++;
      end
      check("abort_nodone", n_done, 0);
      do_op(1'b0, 4'd2, 4'd3, 6);

      // Exhaustive sweep through each port
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               do_op(p[0], W'(a), W'(b), a * b);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 249) == 0);
         if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
         end
         if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom);
         end
         tick();
         if (e_gnt0) req0 = 1'b0;
         if (e_gnt1) req1 = 1'b0;
      end
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
